// File: rtl/mp_job_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mp_job_pkg                                                    |
// | Purpose  : Shared constants for the per-PASID job queue controller:      |
// |            register offsets, default read word, descriptor field         |
// |            positions, status bit positions and FSM state encodings.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package mp_job_pkg;

  // Register offsets, decoded from addr[20:0]
  localparam int OFF_WIDTH = 21;
  localparam logic [OFF_WIDTH-1:0] OFF_CONTROL = 21'h24;
  localparam logic [OFF_WIDTH-1:0] OFF_INIT_LO = 21'h28;
  localparam logic [OFF_WIDTH-1:0] OFF_INIT_HI = 21'h2C;
  localparam logic [OFF_WIDTH-1:0] OFF_CMPL_LO = 21'h30;
  localparam logic [OFF_WIDTH-1:0] OFF_CMPL_HI = 21'h34;
  localparam logic [OFF_WIDTH-1:0] OFF_STATUS  = 21'h38;
  localparam logic [OFF_WIDTH-1:0] OFF_STATS   = 21'h3C;

  // PASID sits directly above the 22-bit per-process window
  localparam int PASID_LSB = 22;

  // Value returned for unmapped offsets
  localparam logic [31:0] DEFAULT_RD = 32'h5A5A_A5A5;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Descriptor layout: {pad, ctrl[15:8], pasid, init_hi, init_lo}
  localparam int DESC_INIT_LO_LSB = 0;
  localparam int DESC_INIT_HI_LSB = 32;
  localparam int DESC_PASID_LSB   = 64;
  localparam int DESC_CTRL_WIDTH  = 8;
  localparam int CTRL_FIELD_LSB   = 8;   // ctrl byte taken from CONTROL[15:8]

  // STATUS register fields
  localparam int STATUS_OVF_BIT = 31;

  // Write and read channel state machines
  typedef enum logic [1:0] {
    WS_IDLE = 2'd0,
    WS_DATA = 2'd1,
    WS_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [0:0] {
    RS_IDLE = 1'b0,
    RS_DATA = 1'b1
  } rd_state_t;

  // The ctrl byte floats above the PASID field, so its position scales with it
  function automatic int desc_ctrl_lsb(input int pasid_width);
    return DESC_PASID_LSB + pasid_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : addr_ram                                                      |
// | Purpose  : Distributed RAM, one synchronous write port and two           |
// |            asynchronous read ports. Contents are not reset.              |
// | Ports    : clk, we/waddr/wdata (write), raddr_a/rdata_a and              |
// |            raddr_b/rdata_b (async reads).                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module addr_ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A read in the same cycle as a write to that word sees the old value
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule
`default_nettype wire

// File: rtl/mp_job_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mp_job_fifo                                                   |
// | Purpose  : DEPTH x WIDTH synchronous FIFO holding job descriptors.       |
// |            Push while full is accepted only when a pop happens in the    |
// |            same cycle. Pointers wrap mod DEPTH (power of two).           |
// | Ports    : clk, rst_n, push/din, pop/dout (head entry), count,           |
// |            full, empty.                                                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mp_job_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 88
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/mp_job_queue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mp_job_queue_ctrl                                             |
// | Purpose  : AXI-Lite slave for per-PASID job submission. CONTROL writes   |
// |            enqueue a descriptor {ctrl, pasid, init_hi, init_lo} into a   |
// |            DEPTH-entry FIFO drained by the job dispatcher. Per-PASID     |
// |            INIT/CMPL words live in distributed RAM, strobe-merged.       |
// | Ports    : clk, rst_n (async, active low); s_axi_* AXI-Lite slave;       |
// |            cmpl_ram_* completion-address shadow strobe/data;             |
// |            job_info_o/job_valid_o/job_ready_i dispatcher interface;      |
// |            job_count_o queue occupancy.                                  |
// | Options  : MPQ_STATS_EN adds enqueue/dequeue counters at offset 0x3C.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mp_job_queue_ctrl
  import mp_job_pkg::*;
#(
  parameter int PASID_WIDTH = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int PINFO_WIDTH = 88
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]      s_axi_awaddr,
  input  logic [2:0]                 s_axi_awprot,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  input  logic [DATA_WIDTH-1:0]      s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]    s_axi_wstrb,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  output logic [1:0]                 s_axi_bresp,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]      s_axi_araddr,
  input  logic [2:0]                 s_axi_arprot,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic [DATA_WIDTH-1:0]      s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic [PASID_WIDTH-1:0]     cmpl_ram_addr_o,
  output logic                       cmpl_ram_lo_o,
  output logic                       cmpl_ram_hi_o,
  output logic [31:0]                cmpl_ram_data_o,
  output logic [PINFO_WIDTH-1:0]     job_info_o,
  output logic                       job_valid_o,
  input  logic                       job_ready_i,
  output logic [$clog2(DEPTH):0]     job_count_o
);

  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int CTRL_LSB = desc_ctrl_lsb(PASID_WIDTH);

  // Write channel state
  wr_state_t               wr_state;
  logic                    awready_q;
  logic                    bvalid_q;
  logic [OFF_WIDTH-1:0]    wr_off;
  logic [PASID_WIDTH-1:0]  wr_pasid;
  logic [16:0]             stall_cnt;
  logic                    overflow;
  logic [DATA_WIDTH-1:0]   ctrl_reg;

  // Read channel state
  rd_state_t               rd_state;
  logic                    arready_q;
  logic                    rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [OFF_WIDTH-1:0]    rd_off;
  logic [PASID_WIDTH-1:0]  rd_pasid;

  logic [DATA_WIDTH-1:0]   init_lo_wr, init_hi_wr, cmpl_lo_wr, cmpl_hi_wr;
  logic [DATA_WIDTH-1:0]   init_lo_rd, init_hi_rd, cmpl_lo_rd, cmpl_hi_rd;
  logic [DATA_WIDTH-1:0]   old_word;
  logic [DATA_WIDTH-1:0]   merged;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   status_word;
  logic [DATA_WIDTH-1:0]   stats_word;
  logic [PINFO_WIDTH-1:0]  desc;

  logic                    fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [CNT_W-1:0]        fifo_count;
  logic                    full_blocked;
  logic                    stall_timeout;
  logic                    w_hs;
  logic                    w_is_ctrl;
  logic                    job_drop;

  assign rd_off   = s_axi_araddr[OFF_WIDTH-1:0];
  assign rd_pasid = s_axi_araddr[PASID_LSB +: PASID_WIDTH];

  // A CONTROL write may only land when a slot is free or one frees this cycle
  assign fifo_pop      = job_valid_o & job_ready_i;
  assign full_blocked  = fifo_full & ~fifo_pop;
  assign w_is_ctrl     = (wr_off == OFF_CONTROL);
  assign stall_timeout = stall_cnt[16];

  // wready stays combinational so a pop in the same cycle releases the stall
  assign s_axi_wready = (wr_state == WS_DATA) &&
                        !(w_is_ctrl && full_blocked && !stall_timeout);
  assign w_hs         = s_axi_wvalid & s_axi_wready;
  assign fifo_push    = w_hs & w_is_ctrl & ~full_blocked;
  assign job_drop     = w_hs & w_is_ctrl & full_blocked;

  // Old word for the byte-lane merge, read from the async port at the write PASID
  always_comb begin
    old_word = '0;
    case (wr_off)
      OFF_CONTROL: old_word = ctrl_reg;
      OFF_INIT_LO: old_word = init_lo_wr;
      OFF_INIT_HI: old_word = init_hi_wr;
      OFF_CMPL_LO: old_word = cmpl_lo_wr;
      OFF_CMPL_HI: old_word = cmpl_hi_wr;
      default:     old_word = '0;
    endcase
    merged = old_word;
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (s_axi_wstrb[b]) merged[8*b +: 8] = s_axi_wdata[8*b +: 8];
    end
  end

  always_comb begin
    desc = '0;
    desc[DESC_INIT_LO_LSB +: 32]         = init_lo_wr;
    desc[DESC_INIT_HI_LSB +: 32]         = init_hi_wr;
    desc[DESC_PASID_LSB +: PASID_WIDTH]  = wr_pasid;
    desc[CTRL_LSB +: DESC_CTRL_WIDTH]    = merged[CTRL_FIELD_LSB +: DESC_CTRL_WIDTH];
  end

  addr_ram #(.ADDR_WIDTH(PASID_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_init_lo (
    .clk(clk), .we(w_hs && wr_off == OFF_INIT_LO), .waddr(wr_pasid), .wdata(merged),
    .raddr_a(wr_pasid), .rdata_a(init_lo_wr), .raddr_b(rd_pasid), .rdata_b(init_lo_rd)
  );
  addr_ram #(.ADDR_WIDTH(PASID_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_init_hi (
    .clk(clk), .we(w_hs && wr_off == OFF_INIT_HI), .waddr(wr_pasid), .wdata(merged),
    .raddr_a(wr_pasid), .rdata_a(init_hi_wr), .raddr_b(rd_pasid), .rdata_b(init_hi_rd)
  );
  addr_ram #(.ADDR_WIDTH(PASID_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_cmpl_lo (
    .clk(clk), .we(w_hs && wr_off == OFF_CMPL_LO), .waddr(wr_pasid), .wdata(merged),
    .raddr_a(wr_pasid), .rdata_a(cmpl_lo_wr), .raddr_b(rd_pasid), .rdata_b(cmpl_lo_rd)
  );
  addr_ram #(.ADDR_WIDTH(PASID_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_cmpl_hi (
    .clk(clk), .we(w_hs && wr_off == OFF_CMPL_HI), .waddr(wr_pasid), .wdata(merged),
    .raddr_a(wr_pasid), .rdata_a(cmpl_hi_wr), .raddr_b(rd_pasid), .rdata_b(cmpl_hi_rd)
  );

  mp_job_fifo #(.DEPTH(DEPTH), .WIDTH(PINFO_WIDTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (desc),
    .pop   (job_ready_i),
    .dout  (job_info_o),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign job_valid_o = ~fifo_empty;
  assign job_count_o = fifo_count;

  // Completion-address shadow strobes fire in the W handshake cycle itself
  assign cmpl_ram_addr_o = wr_pasid;
  assign cmpl_ram_lo_o   = w_hs && (wr_off == OFF_CMPL_LO);
  assign cmpl_ram_hi_o   = w_hs && (wr_off == OFF_CMPL_HI);
  assign cmpl_ram_data_o = merged;

  // Write channel: AW -> W -> B, one transaction outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state  <= WS_IDLE;
      awready_q <= 1'b1;
      bvalid_q  <= 1'b0;
      wr_off    <= '0;
      wr_pasid  <= '0;
      stall_cnt <= '0;
      overflow  <= 1'b0;
      ctrl_reg  <= '0;
    end else begin
      case (wr_state)
        WS_IDLE: begin
          if (s_axi_awvalid && awready_q) begin
            wr_off    <= s_axi_awaddr[OFF_WIDTH-1:0];
            wr_pasid  <= s_axi_awaddr[PASID_LSB +: PASID_WIDTH];
            awready_q <= 1'b0;
            wr_state  <= WS_DATA;
          end
        end
        WS_DATA: begin
          // Count cycles spent blocked on a full queue; saturates at 2^16
          if (w_is_ctrl && full_blocked) begin
            if (!stall_cnt[16]) stall_cnt <= stall_cnt + 17'd1;
          end else begin
            stall_cnt <= '0;
          end
          if (w_hs) begin
            stall_cnt <= '0;
            bvalid_q  <= 1'b1;
            wr_state  <= WS_RESP;
          end
        end
        WS_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wr_state  <= WS_IDLE;
          end
        end
        default: begin
          wr_state  <= WS_IDLE;
          awready_q <= 1'b1;
          bvalid_q  <= 1'b0;
        end
      endcase

      if (w_hs && wr_off == OFF_CONTROL) ctrl_reg <= merged;

      // Overflow only records a job dropped after the stall timed out
      if (job_drop) begin
        overflow <= 1'b1;
      end else if (w_hs && wr_off == OFF_STATUS &&
                   s_axi_wstrb[STATUS_OVF_BIT/8] && s_axi_wdata[STATUS_OVF_BIT]) begin
        overflow <= 1'b0;
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = RESP_OKAY;

  always_comb begin
    status_word = '0;
    status_word[STATUS_OVF_BIT] = overflow;
    status_word[CNT_W-1:0]      = fifo_count;
  end

`ifdef MPQ_STATS_EN
  logic [15:0] stat_enq;
  logic [15:0] stat_deq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_enq <= '0;
      stat_deq <= '0;
    end else if (w_hs && wr_off == OFF_STATS) begin
      stat_enq <= '0;
      stat_deq <= '0;
    end else begin
      if (fifo_push && stat_enq != 16'hFFFF) stat_enq <= stat_enq + 16'd1;
      if (fifo_pop  && stat_deq != 16'hFFFF) stat_deq <= stat_deq + 16'd1;
    end
  end

  assign stats_word = {stat_enq, stat_deq};
`else
  assign stats_word = DEFAULT_RD;
`endif

  always_comb begin
    rd_word = DEFAULT_RD;
    case (rd_off)
      OFF_CONTROL: rd_word = ctrl_reg;
      OFF_INIT_LO: rd_word = init_lo_rd;
      OFF_INIT_HI: rd_word = init_hi_rd;
      OFF_CMPL_LO: rd_word = cmpl_lo_rd;
      OFF_CMPL_HI: rd_word = cmpl_hi_rd;
      OFF_STATUS:  rd_word = status_word;
      OFF_STATS:   rd_word = stats_word;
      default:     rd_word = DEFAULT_RD;
    endcase
  end

  // Read channel: data captured at the AR handshake, held until rready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state  <= RS_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (rd_state)
        RS_IDLE: begin
          if (s_axi_arvalid && arready_q) begin
            rdata_q   <= rd_word;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rd_state  <= RS_DATA;
          end
        end
        RS_DATA: begin
          if (s_axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rd_state  <= RS_IDLE;
          end
        end
        default: begin
          rd_state  <= RS_IDLE;
          arready_q <= 1'b1;
          rvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RESP_OKAY;

  logic unused_bits;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

endmodule
`default_nettype wire

// File: tb/tb_mp_job_queue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mp_job_queue_ctrl                                          |
// | Purpose  : Directed self-checking bench for mp_job_queue_ctrl: reset     |
// |            values, descriptor enqueue, strobe merge, full-queue stall    |
// |            and release, push+pop at full, default read with held R,      |
// |            completion strobes, asynchronous reset mid-transaction.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mp_job_queue_ctrl;

  localparam int PW    = 9;
  localparam int DEPTH = 8;
  localparam int PIW   = 88;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_axi_awvalid = 1'b0, s_axi_awready;
  logic [31:0] s_axi_awaddr = '0;
  logic [2:0]  s_axi_awprot = '0;
  logic        s_axi_wvalid = 1'b0, s_axi_wready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_bvalid, s_axi_bready = 1'b0;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid = 1'b0, s_axi_arready;
  logic [31:0] s_axi_araddr = '0;
  logic [2:0]  s_axi_arprot = '0;
  logic        s_axi_rvalid, s_axi_rready = 1'b0;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic [PW-1:0] cmpl_ram_addr_o;
  logic        cmpl_ram_lo_o, cmpl_ram_hi_o;
  logic [31:0] cmpl_ram_data_o;
  logic [PIW-1:0] job_info_o;
  logic        job_valid_o;
  logic        job_ready_i = 1'b0;
  logic [3:0]  job_count_o;

  int checks = 0;
  int failures = 0;

  mp_job_queue_ctrl #(
    .PASID_WIDTH(PW), .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .PINFO_WIDTH(PIW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .cmpl_ram_addr_o(cmpl_ram_addr_o), .cmpl_ram_lo_o(cmpl_ram_lo_o),
    .cmpl_ram_hi_o(cmpl_ram_hi_o), .cmpl_ram_data_o(cmpl_ram_data_o),
    .job_info_o(job_info_o), .job_valid_o(job_valid_o), .job_ready_i(job_ready_i),
    .job_count_o(job_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] a(input int pasid, input logic [20:0] off);
    logic [31:0] r;
    r = '0;
    r[22 +: PW] = pasid[PW-1:0];
    r[20:0] = off;
    return r;
  endfunction

  function automatic logic [7:0] head_ctrl();
    return job_info_o[64+PW +: 8];
  endfunction

  task automatic aw_phase(input logic [31:0] addr);
    int n = 0;
    @(negedge clk);
    s_axi_awvalid = 1'b1;
    s_axi_awaddr  = addr;
    while (s_axi_awready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("aw_timeout", s_axi_awready, 1'b1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic w_phase(input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    s_axi_wvalid = 1'b1;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    #1;
    while (s_axi_wready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) chk("w_timeout", s_axi_wready, 1'b1);
    @(negedge clk);
    s_axi_wvalid = 1'b0;
  endtask

  task automatic b_phase();
    int n = 0;
    while (s_axi_bvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("b_timeout", s_axi_bvalid, 1'b1);
    chk("bresp", s_axi_bresp, 2'b00);
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    aw_phase(addr);
    w_phase(data, strb);
    b_phase();
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    int n = 0;
    @(negedge clk);
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = addr;
    while (s_axi_arready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("ar_timeout", s_axi_arready, 1'b1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (s_axi_rvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("r_timeout", s_axi_rvalid, 1'b1);
    data = s_axi_rdata;
    chk("rresp", s_axi_rresp, 2'b00);
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
  endtask

  initial begin
    logic [31:0]    d;
    logic [PIW-1:0] exp_desc;
    logic [31:0]    held;

    // ---------------- reset values
    #12;
    chk("rst_awready", s_axi_awready, 1'b1);
    chk("rst_arready", s_axi_arready, 1'b1);
    chk("rst_wready",  s_axi_wready, 1'b0);
    chk("rst_bvalid",  s_axi_bvalid, 1'b0);
    chk("rst_rvalid",  s_axi_rvalid, 1'b0);
    chk("rst_rdata",   s_axi_rdata, 32'h0);
    chk("rst_count",   job_count_o, 4'd0);
    chk("rst_jvalid",  job_valid_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- single job enqueue at PASID 5
    wr(a(5, 21'h28), 32'h0000_1000, 4'hF);
    wr(a(5, 21'h2C), 32'h0000_0002, 4'hF);
    aw_phase(a(5, 21'h24));
    s_axi_wvalid = 1'b1;
    s_axi_wdata  = 32'h0000_AB00;
    s_axi_wstrb  = 4'hF;
    #1;
    chk("t1_wready", s_axi_wready, 1'b1);
    chk("t1_jvalid_before", job_valid_o, 1'b0);
    @(negedge clk);
    s_axi_wvalid = 1'b0;
    #1;
    exp_desc = {7'b0, 8'hAB, 9'd5, 32'h0000_0002, 32'h0000_1000};
    chk("t1_jvalid", job_valid_o, 1'b1);
    chk("t1_bvalid", s_axi_bvalid, 1'b1);
    chk("t1_desc",   job_info_o, exp_desc);
    chk("t1_count",  job_count_o, 4'd1);
    b_phase();
    job_ready_i = 1'b1;
    @(negedge clk);
    job_ready_i = 1'b0;
    #1;
    chk("t1_count_popped", job_count_o, 4'd0);
    chk("t1_jvalid_popped", job_valid_o, 1'b0);

    // ---------------- strobe merge and readback
    wr(a(5, 21'h28), 32'hFFFF_FFFF, 4'hF);
    wr(a(5, 21'h28), 32'h0000_0012, 4'h1);
    rd(a(5, 21'h28), d);
    chk("t2_merge", d, 32'hFFFF_FF12);
    rd(a(5, 21'h2C), d);
    chk("t2_init_hi", d, 32'h0000_0002);
    rd(a(0, 21'h24), d);
    chk("t2_control", d, 32'h0000_AB00);

    // ---------------- completion-address strobe
    aw_phase(a(7, 21'h30));
    s_axi_wvalid = 1'b1;
    s_axi_wdata  = 32'h1234_5678;
    s_axi_wstrb  = 4'hF;
    #1;
    chk("t_cmpl_lo", cmpl_ram_lo_o, 1'b1);
    chk("t_cmpl_hi", cmpl_ram_hi_o, 1'b0);
    chk("t_cmpl_addr", cmpl_ram_addr_o, 9'd7);
    chk("t_cmpl_data", cmpl_ram_data_o, 32'h1234_5678);
    @(negedge clk);
    s_axi_wvalid = 1'b0;
    #1;
    chk("t_cmpl_lo_off", cmpl_ram_lo_o, 1'b0);
    b_phase();
    rd(a(7, 21'h30), d);
    chk("t_cmpl_readback", d, 32'h1234_5678);

    // ---------------- fill queue, then stall the ninth CONTROL write
    for (int i = 0; i < DEPTH; i++) wr(a(5, 21'h24), i << 8, 4'hF);
    #1;
    chk("t3_count_full", job_count_o, 4'd8);
    chk("t3_head0", head_ctrl(), 8'd0);
    aw_phase(a(5, 21'h24));
    s_axi_wvalid = 1'b1;
    s_axi_wdata  = 32'h0000_0800;
    s_axi_wstrb  = 4'hF;
    #1;
    chk("t3_stall_wready", s_axi_wready, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    chk("t3_stall_wready_hold", s_axi_wready, 1'b0);
    chk("t3_stall_count", job_count_o, 4'd8);
    job_ready_i = 1'b1;
    #1;
    chk("t3_release_wready", s_axi_wready, 1'b1);
    @(negedge clk);
    job_ready_i  = 1'b0;
    s_axi_wvalid = 1'b0;
    #1;
    chk("t3_count_after", job_count_o, 4'd8);
    chk("t3_bvalid", s_axi_bvalid, 1'b1);
    chk("t3_head1", head_ctrl(), 8'd1);
    b_phase();

    // ---------------- push and pop in the same cycle at full
    aw_phase(a(5, 21'h24));
    s_axi_wvalid = 1'b1;
    s_axi_wdata  = 32'h0000_0900;
    s_axi_wstrb  = 4'hF;
    job_ready_i  = 1'b1;
    #1;
    chk("t4_wready", s_axi_wready, 1'b1);
    @(negedge clk);
    job_ready_i  = 1'b0;
    s_axi_wvalid = 1'b0;
    #1;
    chk("t4_count", job_count_o, 4'd8);
    chk("t4_head2", head_ctrl(), 8'd2);
    b_phase();

    // ---------------- default read with R held off
    @(negedge clk);
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = a(0, 21'h50);
    #1;
    chk("t5_arready_idle", s_axi_arready, 1'b1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    #1;
    chk("t5_rvalid", s_axi_rvalid, 1'b1);
    chk("t5_rdata", s_axi_rdata, 32'h5A5A_A5A5);
    held = s_axi_rdata;
    repeat (5) @(negedge clk);
    #1;
    chk("t5_rvalid_hold", s_axi_rvalid, 1'b1);
    chk("t5_rdata_hold", s_axi_rdata, 32'h5A5A_A5A5);
    chk("t5_arready_low", s_axi_arready, 1'b0);
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    #1;
    chk("t5_rvalid_done", s_axi_rvalid, 1'b0);
    chk("t5_arready_back", s_axi_arready, 1'b1);
    rd(a(0, 21'h3C), d);
    chk("t5_stats_default", d, 32'h5A5A_A5A5);

    // ---------------- drain to 3 and check STATUS occupancy
    @(negedge clk);
    job_ready_i = 1'b1;
    repeat (5) @(negedge clk);
    job_ready_i = 1'b0;
    #1;
    chk("t6_count3", job_count_o, 4'd3);
    chk("t6_head7", head_ctrl(), 8'd7);
    rd(a(0, 21'h38), d);
    chk("t6_status", d, 32'h0000_0003);

    // ---------------- asynchronous reset with B pending
    aw_phase(a(2, 21'h28));
    w_phase(32'h0000_0055, 4'hF);
    #1;
    chk("t6_bvalid_pending", s_axi_bvalid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_bvalid", s_axi_bvalid, 1'b0);
    chk("t6_rst_jvalid", job_valid_o, 1'b0);
    chk("t6_rst_count", job_count_o, 4'd0);
    chk("t6_rst_awready", s_axi_awready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    rd(a(0, 21'h38), d);
    chk("t6_status_after", d, 32'h0000_0000);
    rd(a(0, 21'h24), d);
    chk("t6_control_after", d, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
